led_scroll_controller: RTL and testbench
========================================

Name: led_scroll_controller

Overview:
- Sequences the 8-digit seven-segment driver by supplying the 32-bit window of hex digits it shows.
- Holds a 16-nibble circular message and advances the window one digit at a time, either from a free-running step timer or from a manual step pulse.
- Accepts a new message through a shadow-buffer write port.
- Applies every change only on the driver's end-of-refresh-frame pulse, so a multiplex sweep never shows a mix of old and new digits.

Parameters:
- MSG_LEN, 16: message length in nibbles. Fixed at 16 so that offset wrap is a 4-bit natural wrap.
- DIGITS, 8: number of displayed digits (an7..an0).
- STEP_CYCLES, 25000000: clock cycles per auto-scroll step. At 100 MHz this is 0.25 s. Must be ≥ 2.
- DEFAULT_MSG, 64'h03604abc00cafe21: message loaded at reset. Nibble 0 is bits [63:60].

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- auto_en  in  1  1 = timer-driven scrolling enabled
- dir  in  1  0 = scroll left (offset+1), 1 = scroll right (offset-1); sampled when a step is applied
- step  in  1  single-cycle manual step request, already synchronised and debounced
- wr_en  in  1  write wr_data into shadow nibble wr_addr
- wr_addr  in  4  shadow nibble index
- wr_data  in  4  nibble value
- wr_commit  in  1  single-cycle request to make the shadow buffer the active message
- frame_done  in  1  single-cycle pulse from the driver at the end of each full anode sweep
- digits  out  32  [31:28] = an7 digit ... [3:0] = an0 digit
- offset  out  4  active message index shown on an7
- busy  out  1  a step or commit is pending
- step_tick  out  1  single-cycle pulse on the edge where an offset change is applied

Behaviour:
- **Reset values:** active = shadow = DEFAULT_MSG; offset = 0; digits = 32'h03604abc; busy = 0; step_tick = 0; timer = 0; all pending flags = 0.
- **Window mapping:** digit k (k = 0 for an7 through 7 for an0) = active[(offset + k) mod 16]. digits is registered and updates on the same edge as offset. No combinational input-to-output paths.
- **Timer:**
  - Counts 0..STEP_CYCLES-1 while auto_en = 1.
  - At terminal count it wraps to 0 and raises a step request for that cycle.
  - auto_en = 0 holds the timer at 0.
- **FSM, states IDLE and PENDING:**
  - IDLE → PENDING on any request (step, timer request, or wr_commit) when frame_done = 0 in that cycle.
  - A request arriving in the same cycle as frame_done is applied on that edge and the FSM stays in IDLE.
  - PENDING → IDLE on the edge where frame_done = 1; all pending actions are applied on that edge.
  - busy = 1 exactly in PENDING.
- **Coalescing:**
  - Any number of step and timer requests before one frame_done produce exactly one step.
  - step and a timer request in the same cycle produce one step.
- **Applying a step:** offset ← offset+1 if dir = 0, otherwise offset−1, wrapping mod 16. step_tick = 1 for one cycle.
- **Applying a commit:** active ← shadow and offset ← 0. Commit takes priority: a step pending together with a commit is discarded, and step_tick stays 0.
- **Shadow writes:**
  - wr_en writes on any cycle, including while busy, and is never visible on digits until a commit is applied.
  - A wr_en and wr_commit in the same cycle: the written nibble is included in the commit.
  - A write after the commit request but before frame_done is also included, since the snapshot is taken at the apply edge.
- **Reset mid-operation:** asynchronous reset clears pending flags, the timer and offset immediately. active and shadow return to DEFAULT_MSG, and any uncommitted writes are lost.

Test Plan:
1. Reset held, then released with auto_en = 0 → digits = 32'h03604abc, offset = 0, busy = 0. With frame_done toggling and no requests, nothing changes.
2. step pulse, dir = 0, then frame_done 5 cycles later → busy = 1 for those cycles; at the frame_done edge offset = 1, digits = 32'h3604abc0, step_tick pulses once. Repeat with dir = 1 from reset → offset = 15, digits = 32'h103604ab.
3. Wrap check: 16 left steps, each followed by frame_done → offset passes 8 (digits 32'h00cafe21) and 9 (digits 32'h0cafe210), then returns to 0 with digits 32'h03604abc.
4. Auto-scroll with STEP_CYCLES = 10 and frame_done every 3 cycles → offset advances exactly once per 10 cycles. Add three manual step pulses before a single frame_done → only one increment.
5. Write shadow nibbles 0..7 with 4'hf, then wr_commit together with a pending step, then frame_done → offset = 0, digits = 32'hffffffff, step_tick = 0. Before frame_done, digits remain unchanged.
6. Assert reset mid-PENDING (step requested, no frame_done yet) → busy, offset and digits go to reset values asynchronously. After release, frame_done causes no step.

Source files
------------

// File: rtl/led_scroll_controller.sv
// Scrolling window over a 16-nibble circular message for an 8-digit seven-segment driver.
// All offset/message changes land on the driver's end-of-frame pulse so a sweep never tears.
module led_scroll_controller #(
    parameter int              MSG_LEN     = 16,
    parameter int              DIGITS      = 8,
    parameter int              STEP_CYCLES = 25000000,
    parameter logic [63:0]     DEFAULT_MSG = 64'h03604abc00cafe21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  auto_en,
    input  logic                  dir,
    input  logic                  step,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_commit,
    input  logic                  frame_done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            offset,
    output logic                  busy,
    output logic                  step_tick
);

    localparam int TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    // Index 0 of the nibble arrays is message nibble 0 (the MSB nibble of DEFAULT_MSG).
    function automatic logic [MSG_LEN-1:0][3:0] default_arr();
        logic [MSG_LEN-1:0][3:0] a;
        for (int i = 0; i < MSG_LEN; i++)
            a[i] = DEFAULT_MSG[4*(MSG_LEN-i)-1 -: 4];
        return a;
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [TW-1:0]           r_timer;
    logic                    r_step_pend, w_step_pend_nxt;
    logic                    r_commit_pend, w_commit_pend_nxt;
    logic [MSG_LEN-1:0][3:0] r_active, w_active_nxt;
    logic [MSG_LEN-1:0][3:0] r_shadow, w_shadow_nxt;
    logic [3:0]              r_offset, w_off_nxt;
    logic [4*DIGITS-1:0]     r_digits, w_digits_nxt;
    logic                    r_step_tick;

    logic w_tmr_req, w_step_req, w_any_step, w_any_commit, w_apply;

    assign w_tmr_req    = auto_en && (r_timer == TW'(STEP_CYCLES-1));
    assign w_step_req   = step | w_tmr_req;
    assign w_any_step   = r_step_pend | w_step_req;
    assign w_any_commit = r_commit_pend | wr_commit;
    assign w_apply      = frame_done && (w_any_step || w_any_commit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_timer <= '0;
        else if (!auto_en || w_tmr_req)
            r_timer <= '0;
        else
            r_timer <= r_timer + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_step_pend   <= 1'b0;
            r_commit_pend <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_step_pend   <= w_step_pend_nxt;
            r_commit_pend <= w_commit_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_step_pend_nxt   = r_step_pend;
        w_commit_pend_nxt = r_commit_pend;
        case (r_state)
            S_IDLE: begin
                // A request coinciding with frame_done is applied directly and never pends.
                if (!frame_done && (w_step_req || wr_commit)) begin
                    w_state_nxt       = S_PENDING;
                    w_step_pend_nxt   = w_step_req;
                    w_commit_pend_nxt = wr_commit;
                end
            end
            S_PENDING: begin
                if (frame_done) begin
                    w_state_nxt       = S_IDLE;
                    w_step_pend_nxt   = 1'b0;
                    w_commit_pend_nxt = 1'b0;
                end else begin
                    w_step_pend_nxt   = r_step_pend | w_step_req;
                    w_commit_pend_nxt = r_commit_pend | wr_commit;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Same-cycle writes are folded in so a commit snapshots the freshest shadow.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (wr_en)
            w_shadow_nxt[wr_addr] = wr_data;
    end

    always_comb begin
        w_active_nxt = r_active;
        w_off_nxt    = r_offset;
        if (w_apply) begin
            if (w_any_commit) begin
                w_active_nxt = w_shadow_nxt;
                w_off_nxt    = 4'd0;
            end else if (dir) begin
                w_off_nxt    = r_offset - 4'd1;
            end else begin
                w_off_nxt    = r_offset + 4'd1;
            end
        end
    end

    always_comb begin
        w_digits_nxt = '0;
        for (int k = 0; k < DIGITS; k++)
            w_digits_nxt[4*(DIGITS-1-k) +: 4] = w_active_nxt[w_off_nxt + 4'(k)];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active    <= default_arr();
            r_shadow    <= default_arr();
            r_offset    <= 4'd0;
            r_digits    <= DEFAULT_MSG[63 -: 4*DIGITS];
            r_step_tick <= 1'b0;
        end else begin
            r_active    <= w_active_nxt;
            r_shadow    <= w_shadow_nxt;
            r_offset    <= w_off_nxt;
            r_digits    <= w_digits_nxt;
            r_step_tick <= w_apply && w_any_step && !w_any_commit;
        end
    end

    assign digits    = r_digits;
    assign offset    = r_offset;
    assign busy      = (r_state == S_PENDING);
    assign step_tick = r_step_tick;

endmodule

// File: tb/tb_led_scroll_controller.sv
// Directed bench for led_scroll_controller with a short step timer (STEP_CYCLES = 10).
module tb_led_scroll_controller;

    logic        clk = 1'b0;
    logic        reset, auto_en, dir, step, wr_en, wr_commit, frame_done;
    logic [3:0]  wr_addr, wr_data;
    logic [31:0] digits;
    logic [3:0]  offset;
    logic        busy, step_tick;

    int n_assert = 0;
    int n_fail   = 0;

    led_scroll_controller #(.STEP_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .auto_en(auto_en), .dir(dir), .step(step),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
        .frame_done(frame_done), .digits(digits), .offset(offset), .busy(busy),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; auto_en = 1'b0; dir = 1'b0; step = 1'b0; wr_en = 1'b0;
        wr_addr = 4'd0; wr_data = 4'd0; wr_commit = 1'b0; frame_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_assert++; if (digits !== 32'h03604abc) begin n_fail++; $display("FAIL rst_digits got %h exp %h", digits, 32'h03604abc); end
        n_assert++; if (offset !== 4'd0) begin n_fail++; $display("FAIL rst_offset got %0d exp 0", offset); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_assert++; if (step_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %b exp 0", step_tick); end
        for (int i = 0; i < 6; i++) begin
            frame_done = i[0];
            tick();
            n_assert++; if (offset !== 4'd0 || digits !== 32'h03604abc || busy !== 1'b0)
                begin n_fail++; $display("FAIL idle_frames cyc %0d got off %0d dig %h busy %b exp 0 03604abc 0", i, offset, digits, busy); end
        end
        frame_done = 1'b0;
    endtask

    task automatic test_step_dir();
        do_reset();
        step = 1'b1; tick(); step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_assert++; if (busy !== 1'b1 || offset !== 4'd0) begin n_fail++; $display("FAIL step_pending cyc %0d got busy %b off %0d exp 1 0", i, busy, offset); end
            if (i < 4) tick();
        end
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        n_assert++; if (offset !== 4'd1) begin n_fail++; $display("FAIL left_offset got %0d exp 1", offset); end
        n_assert++; if (digits !== 32'h3604abc0) begin n_fail++; $display("FAIL left_digits got %h exp 3604abc0", digits); end
        n_assert++; if (step_tick !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL left_tick got tick %b busy %b exp 1 0", step_tick, busy); end
        tick();
        n_assert++; if (step_tick !== 1'b0) begin n_fail++; $display("FAIL left_tick_once got %b exp 0", step_tick); end

        do_reset();
        dir = 1'b1; step = 1'b1; tick(); step = 1'b0;
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        n_assert++; if (offset !== 4'd15) begin n_fail++; $display("FAIL right_offset got %0d exp 15", offset); end
        n_assert++; if (digits !== 32'h103604ab) begin n_fail++; $display("FAIL right_digits got %h exp 103604ab", digits); end
        dir = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step = 1'b1; tick(); step = 1'b0;
            frame_done = 1'b1; tick(); frame_done = 1'b0;
            n_assert++; if (offset !== 4'(i)) begin n_fail++; $display("FAIL wrap_offset step %0d got %0d exp %0d", i, offset, 4'(i)); end
            exp_d = (i == 8) ? 32'h00cafe21 : (i == 9) ? 32'h0cafe210 : 32'h03604abc;
            if (i == 8 || i == 9 || i == 16) begin
                n_assert++; if (digits !== exp_d) begin n_fail++; $display("FAIL wrap_digits step %0d got %h exp %h", i, digits, exp_d); end
            end
        end
    endtask

    task automatic test_auto_and_coalesce();
        int ticks;
        do_reset();
        ticks = 0;
        auto_en = 1'b1;
        for (int c = 0; c < 65; c++) begin
            frame_done = (c % 3 == 2);
            tick();
            if (step_tick === 1'b1) ticks++;
        end
        auto_en = 1'b0;
        for (int c = 65; c < 71; c++) begin
            frame_done = (c % 3 == 2);
            tick();
            if (step_tick === 1'b1) ticks++;
        end
        frame_done = 1'b0;
        n_assert++; if (ticks != 6) begin n_fail++; $display("FAIL auto_ticks got %0d exp 6", ticks); end
        n_assert++; if (offset !== 4'd6) begin n_fail++; $display("FAIL auto_offset got %0d exp 6", offset); end

        do_reset();
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        if (step_tick === 1'b1) ticks++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (step_tick === 1'b1) ticks++;
        end
        n_assert++; if (offset !== 4'd1 || ticks != 1) begin n_fail++; $display("FAIL coalesce got off %0d ticks %0d exp 1 1", offset, ticks); end
    endtask

    task automatic test_commit();
        do_reset();
        wr_en = 1'b1; wr_data = 4'hf;
        for (int i = 0; i < 8; i++) begin
            wr_addr = 4'(i); tick();
        end
        wr_en = 1'b0;
        n_assert++; if (digits !== 32'h03604abc) begin n_fail++; $display("FAIL shadow_hidden got %h exp 03604abc", digits); end
        step = 1'b1; wr_commit = 1'b1; tick(); step = 1'b0; wr_commit = 1'b0;
        tick();
        n_assert++; if (digits !== 32'h03604abc || busy !== 1'b1) begin n_fail++; $display("FAIL commit_wait got %h busy %b exp 03604abc 1", digits, busy); end
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        n_assert++; if (offset !== 4'd0 || digits !== 32'hffffffff) begin n_fail++; $display("FAIL commit_apply got off %0d dig %h exp 0 ffffffff", offset, digits); end
        n_assert++; if (step_tick !== 1'b0) begin n_fail++; $display("FAIL commit_tick got %b exp 0", step_tick); end

        // Write and commit together on a frame edge: applied at once, including the write.
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 4'h5; wr_commit = 1'b1; frame_done = 1'b1;
        tick();
        wr_en = 1'b0; wr_commit = 1'b0; frame_done = 1'b0;
        n_assert++; if (busy !== 1'b0 || offset !== 4'd0) begin n_fail++; $display("FAIL commit_same_edge got busy %b off %0d exp 0 0", busy, offset); end
        step = 1'b1; frame_done = 1'b1; tick(); step = 1'b0; frame_done = 1'b0;
        n_assert++; if (digits !== 32'hfffffff5 || offset !== 4'd1) begin n_fail++; $display("FAIL commit_with_write got %h off %0d exp fffffff5 1", digits, offset); end
    endtask

    task automatic test_reset_mid_pending();
        do_reset();
        step = 1'b1; frame_done = 1'b1; tick(); frame_done = 1'b0; tick();
        tick(); step = 1'b0;
        n_assert++; if (busy !== 1'b1 || offset !== 4'd1) begin n_fail++; $display("FAIL pre_reset got busy %b off %0d exp 1 1", busy, offset); end
        #2 reset = 1'b1;
        #1;
        n_assert++; if (busy !== 1'b0 || offset !== 4'd0 || digits !== 32'h03604abc)
            begin n_fail++; $display("FAIL async_reset got busy %b off %0d dig %h exp 0 0 03604abc", busy, offset, digits); end
        tick();
        reset = 1'b0;
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        n_assert++; if (offset !== 4'd0 || step_tick !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL post_reset got off %0d tick %b busy %b exp 0 0 0", offset, step_tick, busy); end
    endtask

    initial begin
        test_reset();
        test_step_dir();
        test_wrap();
        test_auto_and_coalesce();
        test_commit();
        test_reset_mid_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
